mem_rd_checker: RTL and testbench

Downstream consumer of the memory controller's read-data stream. Accepts one read word per qualified cycle, compares each word against a deterministic expected pattern, and accumulates a rotating checksum, error count and first-failing address over one full memory sweep of 2**ADDR words. Publishes a pass/fail verdict for the self-test harness at the top level.

---
 rtl/mem_rd_checker.sv | 111 +++++++++++
 tb/tb_mem_rd_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_rd_checker.sv
// Read-data stream checker: compares each accepted word against SEED+index over one
// 2**ADDR-word sweep, accumulating error count, first failing address and a rotating checksum.
//
// state | meaning
// IDLE  | waiting for start, read stream ignored
// RUN   | accepting one word per rd_valid cycle
// DONE  | sweep complete, verdict and results held
module mem_rd_checker #(
  parameter int          WIDTH = 32,
  parameter int          ADDR  = 10,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rd_valid,
  input  logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ADDR:0]    err_count,
  output logic             first_err_valid,
  output logic [ADDR-1:0]  first_err_addr,
  output logic [WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
  localparam logic [ADDR:0]    LAST   = {1'b0, {ADDR{1'b1}}};

  state_t           state, state_nxt;
  logic [ADDR:0]    idx;
  logic             clear, accept, mismatch;
  logic [WIDTH-1:0] expected;
  logic [ADDR:0]    err_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      RUN: begin
        if (rd_valid) begin
          accept = 1'b1;
          if (idx == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign expected = SEED_W + WIDTH'(idx);
  assign mismatch = accept && (rd_data != expected);
  assign err_nxt  = clear ? '0 : err_count + (ADDR+1)'(mismatch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx             <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      checksum        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      if (clear) begin
        idx             <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
        checksum        <= '0;
      end else if (accept) begin
        // idx returns to zero on the last word so it never exceeds 2**ADDR-1
        idx       <= (idx == LAST) ? '0 : idx + (ADDR+1)'(1);
        err_count <= err_nxt;
        checksum  <= {checksum[WIDTH-2:0], checksum[WIDTH-1]} ^ rd_data;
        if (mismatch && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= idx[ADDR-1:0];
        end
      end
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      pass <= (state_nxt == DONE) && (err_nxt == '0);
    end
  end

endmodule

// File: tb/tb_mem_rd_checker.sv
// Self-checking bench for mem_rd_checker (ADDR=4, SEED=1): directed sweeps plus randomized
// data and rd_valid gaps, checked against a word-list reference model.
module tb_mem_rd_checker;
  localparam int          WIDTH = 32;
  localparam int          ADDR  = 4;
  localparam int          N     = 16;
  localparam logic [31:0] SEED  = 32'h0000_0001;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             rd_valid = 1'b0;
  logic [WIDTH-1:0] rd_data = '0;
  logic             busy, done, pass, first_err_valid;
  logic [ADDR:0]    err_count;
  logic [ADDR-1:0]  first_err_addr;
  logic [WIDTH-1:0] checksum;

  int checks = 0;
  int errors = 0;
  logic [31:0] w [N];

  mem_rd_checker #(.WIDTH(WIDTH), .ADDR(ADDR), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected summary before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_err"}, 64'(err_count), 64'd0);
    chk({tag, "_fev"}, 64'(first_err_valid), 64'd0);
    chk({tag, "_fea"}, 64'(first_err_addr), 64'd0);
    chk({tag, "_cs"}, 64'(checksum), 64'd0);
  endtask

  task automatic fill_clean();
    for (int i = 0; i < N; i++) w[i] = SEED + 32'(i);
  endtask

  // Drive start then all N words of w[], optionally with gaps and ignored start pulses,
  // and compare final results against a plain model of the word list.
  task automatic run_sweep(input string tag, input int gap_pct, input bit noise);
    logic [31:0] cs;
    int errs, first;
    cs = '0; errs = 0; first = -1;
    start = 1'b1; tick(); start = 1'b0;
    chk({tag, "_start_busy"}, 64'(busy), 64'd1);
    chk({tag, "_start_err"}, 64'(err_count), 64'd0);
    chk({tag, "_start_fev"}, 64'(first_err_valid), 64'd0);
    chk({tag, "_start_cs"}, 64'(checksum), 64'd0);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < 4; g++) begin
        if ($urandom_range(99) >= gap_pct) break;
        rd_valid = 1'b0; rd_data = $urandom;
        start = noise ? 1'($urandom_range(1)) : 1'b0;
        tick();
      end
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      rd_valid = 1'b1; rd_data = w[i];
      tick();
      if (w[i] != SEED + 32'(i)) begin
        errs++;
        if (first < 0) first = i;
      end
      cs = {cs[30:0], cs[31]} ^ w[i];
      if (i < N - 1) begin
        chk({tag, "_mid_busy"}, 64'(busy), 64'd1);
        chk({tag, "_mid_done"}, 64'(done), 64'd0);
        chk({tag, "_mid_err"}, 64'(err_count), 64'(errs));
      end
    end
    rd_valid = 1'b0; start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_pass"}, 64'(pass), 64'(errs == 0));
    chk({tag, "_err"}, 64'(err_count), 64'(errs));
    chk({tag, "_fev"}, 64'(first_err_valid), 64'(first >= 0));
    chk({tag, "_fea"}, 64'(first_err_addr), (first >= 0) ? 64'(first) : 64'd0);
    chk({tag, "_cs"}, 64'(checksum), 64'(cs));
  endtask

  initial begin
    logic [31:0] hold_cs;
    #12;
    chk_zero("reset");
    @(negedge clk); rst = 1'b1;
    tick();
    chk_zero("post_reset");

    // rd_valid in IDLE is ignored
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1; rd_data = $urandom; tick();
    end
    rd_valid = 1'b0;
    chk_zero("idle_valid");

    fill_clean();
    run_sweep("clean", 0, 1'b0);

    // rd_valid in DONE is ignored, results hold
    hold_cs = checksum;
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1; rd_data = $urandom; tick();
    end
    rd_valid = 1'b0;
    chk("done_hold_done", 64'(done), 64'd1);
    chk("done_hold_pass", 64'(pass), 64'd1);
    chk("done_hold_cs", 64'(checksum), 64'(hold_cs));

    fill_clean();
    w[5] = 32'h0000_DEAD;
    run_sweep("single_err", 0, 1'b0);

    for (int i = 0; i < N; i++) w[i] = '0;
    run_sweep("all_fail", 0, 1'b0);
    chk("all_fail_count16", 64'(err_count), 64'd16);

    fill_clean();
    run_sweep("restart_gapped", 40, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        w[i] = ($urandom_range(3) == 0) ? $urandom : SEED + 32'(i);
      run_sweep("random", 30, 1'b1);
    end

    // Asynchronous reset between clock edges mid-sweep
    fill_clean();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd_valid = 1'b1; rd_data = (i == 2) ? 32'hBAD : w[i]; tick();
    end
    rd_valid = 1'b0;
    chk("pre_rst_err", 64'(err_count), 64'd1);
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    tick(); tick();
    @(negedge clk); rst = 1'b1;
    tick();
    chk_zero("rst_release");
    run_sweep("after_rst", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
